btb_tagged: RTL and testbench

//  Parametrised, tagged, direct-mapped branch target buffer with 2-bit hysteresis counters.

---
 rtl/btb_tagged_pkg.sv | 38 +++
 rtl/btb_tagged_sat_ctr.sv | 39 +++
 rtl/btb_tagged.sv | 178 +++++++++++++++++
 tb/tb_btb_tagged.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/btb_tagged_pkg.sv
// Shared types and helpers for the tagged branch target buffer.
// Holds the 2-bit confidence encodings, the update action decode and the counter step function.
package btb_tagged_pkg;

    localparam logic [1:0] CTR_SNT   = 2'd0;
    localparam logic [1:0] CTR_WNT   = 2'd1;
    localparam logic [1:0] CTR_WT    = 2'd2;
    localparam logic [1:0] CTR_ST    = 2'd3;
    localparam logic [1:0] CTR_INIT  = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    typedef enum logic [2:0] {
        UPD_NONE      = 3'd0,
        UPD_HIT_TAKEN = 3'd1,
        UPD_HIT_NT    = 3'd2,
        UPD_ALLOC     = 3'd3,
        UPD_HYST      = 3'd4
    } upd_act_e;

    // One saturating step of a 2-bit counter; simultaneous inc and dec cancel.
    function automatic logic [1:0] sat_step(input logic [1:0] cur,
                                            input logic       inc,
                                            input logic       dec);
        logic [1:0] nxt;
        nxt = cur;
        if (inc && !dec) begin
            if (cur != CTR_ST) nxt = cur + 2'd1;
            else               nxt = cur;
        end else if (dec && !inc) begin
            if (cur != CTR_SNT) nxt = cur - 2'd1;
            else                nxt = cur;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btb_tagged_sat_ctr.sv
// 2-bit saturating confidence counter for one BTB entry.
// A load takes priority over inc/dec; reset returns it to weakly-not-taken.
module btb_tagged_sat_ctr
    import btb_tagged_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  logic [1:0] load_val,
    output logic [1:0] ctr
);

    logic [1:0] ctr_r;
    logic [1:0] ctr_next_s;

    // Next counter value: load, else saturating step.
    always_comb begin
        ctr_next_s = ctr_r;
        if (load) begin
            ctr_next_s = load_val;
        end else begin
            ctr_next_s = sat_step(ctr_r, inc, dec);
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctr_r <= CTR_INIT;
        end else begin
            ctr_r <= ctr_next_s;
        end
    end

    assign ctr = ctr_r;

endmodule

// File: rtl/btb_tagged.sv
// Tagged direct-mapped branch target buffer with 2-bit hysteresis counters.
// Zero-latency combinational lookup from registered state; updates from commit at the clock edge.
module btb_tagged
    import btb_tagged_pkg::*;
#(
    parameter int IDX_BITS   = 4,
    parameter int TAG_BITS   = 8,
    parameter int ALIGN_BITS = 2,
    parameter int STAT_BITS  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 lookup_valid_in,
    input  logic [63:0]          lookup_pc_in,
    output logic                 hit_out,
    output logic                 taken_out,
    output logic [63:0]          PPC_out,
    input  logic                 upd_valid_in,
    input  logic [63:0]          upd_pc_in,
    input  logic                 upd_taken_in,
    input  logic [63:0]          upd_target_in,
    input  logic                 flush_in,
    output logic [STAT_BITS-1:0] lookups_out,
    output logic [STAT_BITS-1:0] hits_out
);

    localparam int ENTRIES = 2 ** IDX_BITS;
    localparam int TAG_LO  = ALIGN_BITS + IDX_BITS;
    localparam int TAG_HI  = ALIGN_BITS + IDX_BITS + TAG_BITS - 1;

    logic                valid_s  [ENTRIES];
    logic [TAG_BITS-1:0] tag_s    [ENTRIES];
    logic [63:0]         target_s [ENTRIES];
    logic [1:0]          ctr_s    [ENTRIES];

    logic [IDX_BITS-1:0] lk_idx_s;
    logic [TAG_BITS-1:0] lk_tag_s;
    logic [IDX_BITS-1:0] upd_idx_s;
    logic [TAG_BITS-1:0] upd_tag_s;
    logic                upd_hit_s;
    upd_act_e            upd_act_s;

    logic [STAT_BITS-1:0] lookups_r;
    logic [STAT_BITS-1:0] hits_r;
    logic                 unused_pc_bits_s;

    assign lk_idx_s  = lookup_pc_in[TAG_LO-1:ALIGN_BITS];
    assign lk_tag_s  = lookup_pc_in[TAG_HI:TAG_LO];
    assign upd_idx_s = upd_pc_in[TAG_LO-1:ALIGN_BITS];
    assign upd_tag_s = upd_pc_in[TAG_HI:TAG_LO];
    assign unused_pc_bits_s = ^{upd_pc_in[63:TAG_HI+1], upd_pc_in[ALIGN_BITS-1:0]};

    assign hit_out   = valid_s[lk_idx_s] && (tag_s[lk_idx_s] == lk_tag_s);
    assign taken_out = hit_out && ctr_s[lk_idx_s][1];
    assign PPC_out   = taken_out ? target_s[lk_idx_s] : (lookup_pc_in + 64'd4);

    assign upd_hit_s = valid_s[upd_idx_s] && (tag_s[upd_idx_s] == upd_tag_s);

    // Classify the resolved branch; a flush in the same cycle drops it.
    always_comb begin
        upd_act_s = UPD_NONE;
        if (upd_valid_in && !flush_in) begin
            if (upd_hit_s) begin
                if (upd_taken_in) upd_act_s = UPD_HIT_TAKEN;
                else              upd_act_s = UPD_HIT_NT;
            end else if (upd_taken_in) begin
                // A confident resident entry resists one eviction attempt per update.
                if (!valid_s[upd_idx_s] || !ctr_s[upd_idx_s][1]) upd_act_s = UPD_ALLOC;
                else                                             upd_act_s = UPD_HYST;
            end else begin
                upd_act_s = UPD_NONE;
            end
        end else begin
            upd_act_s = UPD_NONE;
        end
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        logic                sel_s;
        logic                valid_r;
        logic                valid_next_s;
        logic [TAG_BITS-1:0] tag_r;
        logic [TAG_BITS-1:0] tag_next_s;
        logic [63:0]         target_r;
        logic [63:0]         target_next_s;
        logic                inc_s;
        logic                dec_s;
        logic                load_s;
        logic [1:0]          entry_ctr_s;

        assign sel_s = (upd_idx_s == IDX_BITS'(i));

        // Per-entry next state from flush and the decoded update action.
        always_comb begin
            valid_next_s  = valid_r;
            tag_next_s    = tag_r;
            target_next_s = target_r;
            inc_s         = 1'b0;
            dec_s         = 1'b0;
            load_s        = 1'b0;
            if (flush_in) begin
                valid_next_s = 1'b0;
            end else if (sel_s) begin
                case (upd_act_s)
                    UPD_HIT_TAKEN: begin
                        inc_s         = 1'b1;
                        target_next_s = upd_target_in;
                    end
                    UPD_HIT_NT: dec_s = 1'b1;
                    UPD_ALLOC: begin
                        valid_next_s  = 1'b1;
                        tag_next_s    = upd_tag_s;
                        target_next_s = upd_target_in;
                        load_s        = 1'b1;
                    end
                    UPD_HYST: dec_s = 1'b1;
                    default: begin
                        inc_s = 1'b0;
                        dec_s = 1'b0;
                    end
                endcase
            end else begin
                valid_next_s = valid_r;
            end
        end

        // Entry valid/tag/target registers.
        always_ff @(posedge clock) begin
            if (reset) begin
                valid_r  <= 1'b0;
                tag_r    <= {TAG_BITS{1'b0}};
                target_r <= 64'd0;
            end else begin
                valid_r  <= valid_next_s;
                tag_r    <= tag_next_s;
                target_r <= target_next_s;
            end
        end

        btb_tagged_sat_ctr u_ctr (
            .clock    (clock),
            .reset    (reset),
            .inc      (inc_s),
            .dec      (dec_s),
            .load     (load_s),
            .load_val (CTR_ALLOC),
            .ctr      (entry_ctr_s)
        );

        assign valid_s[i]  = valid_r;
        assign tag_s[i]    = tag_r;
        assign target_s[i] = target_r;
        assign ctr_s[i]    = entry_ctr_s;
    end

    // Saturating lookup and hit statistics; flush leaves them alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            lookups_r <= {STAT_BITS{1'b0}};
            hits_r    <= {STAT_BITS{1'b0}};
        end else begin
            if (lookup_valid_in && (lookups_r != {STAT_BITS{1'b1}})) begin
                lookups_r <= lookups_r + STAT_BITS'(1);
            end else begin
                lookups_r <= lookups_r;
            end
            if (lookup_valid_in && hit_out && (hits_r != {STAT_BITS{1'b1}})) begin
                hits_r <= hits_r + STAT_BITS'(1);
            end else begin
                hits_r <= hits_r;
            end
        end
    end

    assign lookups_out = lookups_r;
    assign hits_out    = hits_r;

endmodule

// File: tb/tb_btb_tagged.sv
// Directed table-driven bench for btb_tagged: lookup/update/flush vectors plus reset sequences.
module tb_btb_tagged;

    logic        clock;
    logic        reset;
    logic        lookup_valid_in;
    logic [63:0] lookup_pc_in;
    logic        hit_out;
    logic        taken_out;
    logic [63:0] PPC_out;
    logic        upd_valid_in;
    logic [63:0] upd_pc_in;
    logic        upd_taken_in;
    logic [63:0] upd_target_in;
    logic        flush_in;
    logic [31:0] lookups_out;
    logic [31:0] hits_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        lkv;
        logic [63:0] lkpc;
        logic        uv;
        logic [63:0] upc;
        logic        ut;
        logic [63:0] utgt;
        logic        fl;
        logic        eh;
        logic        et;
        logic [63:0] eppc;
    } vec_t;

    vec_t vecs[$];

    btb_tagged dut (
        .clock           (clock),
        .reset           (reset),
        .lookup_valid_in (lookup_valid_in),
        .lookup_pc_in    (lookup_pc_in),
        .hit_out         (hit_out),
        .taken_out       (taken_out),
        .PPC_out         (PPC_out),
        .upd_valid_in    (upd_valid_in),
        .upd_pc_in       (upd_pc_in),
        .upd_taken_in    (upd_taken_in),
        .upd_target_in   (upd_target_in),
        .flush_in        (flush_in),
        .lookups_out     (lookups_out),
        .hits_out        (hits_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic lkv, input logic [63:0] lkpc,
                                input logic uv, input logic [63:0] upc, input logic ut,
                                input logic [63:0] utgt, input logic fl,
                                input logic eh, input logic et, input logic [63:0] eppc);
        vec_t v;
        v.lkv = lkv; v.lkpc = lkpc; v.uv = uv; v.upc = upc; v.ut = ut;
        v.utgt = utgt; v.fl = fl; v.eh = eh; v.et = et; v.eppc = eppc;
        return v;
    endfunction

    task automatic check(input string name, input int id, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", name, id, got, exp);
        end
    endtask

    task automatic idle_inputs();
        lookup_valid_in = 1'b0; lookup_pc_in = 64'd0;
        upd_valid_in = 1'b0; upd_pc_in = 64'd0; upd_taken_in = 1'b0;
        upd_target_in = 64'd0; flush_in = 1'b0;
    endtask

    initial begin
        int exp_lk;
        int exp_hits;
        // Entry 0 is shared by 0x100 (tag 0x04), 0x1100 (tag 0x44) and 0x200 (tag 0x08).
        //            lkv  lkpc          uv   upc        ut   utgt      fl   eh   et   eppc
        vecs.push_back(mk(1'b1, 64'h100,  1'b0, 64'h0,    1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 64'h104));
        vecs.push_back(mk(1'b1, 64'h100,  1'b1, 64'h100,  1'b1, 64'h400, 1'b0, 1'b0, 1'b0, 64'h104));
        vecs.push_back(mk(1'b1, 64'h100,  1'b1, 64'h100,  1'b1, 64'h400, 1'b0, 1'b1, 1'b1, 64'h400));
        vecs.push_back(mk(1'b1, 64'h100,  1'b1, 64'h100,  1'b1, 64'h480, 1'b0, 1'b1, 1'b1, 64'h400));
        vecs.push_back(mk(1'b1, 64'h100,  1'b1, 64'h1100, 1'b1, 64'h800, 1'b0, 1'b1, 1'b1, 64'h480));
        vecs.push_back(mk(1'b1, 64'h1100, 1'b1, 64'h1100, 1'b1, 64'h800, 1'b0, 1'b0, 1'b0, 64'h1104));
        vecs.push_back(mk(1'b1, 64'h100,  1'b1, 64'h1100, 1'b1, 64'h800, 1'b0, 1'b1, 1'b0, 64'h104));
        vecs.push_back(mk(1'b1, 64'h1100, 1'b1, 64'h100,  1'b0, 64'h0,   1'b0, 1'b1, 1'b1, 64'h800));
        vecs.push_back(mk(1'b1, 64'h100,  1'b1, 64'h100,  1'b1, 64'h400, 1'b0, 1'b0, 1'b0, 64'h104));
        vecs.push_back(mk(1'b1, 64'h1100, 1'b1, 64'h1100, 1'b1, 64'h900, 1'b0, 1'b1, 1'b0, 64'h1104));
        vecs.push_back(mk(1'b1, 64'h1100, 1'b1, 64'h1100, 1'b0, 64'h0,   1'b0, 1'b1, 1'b1, 64'h900));
        vecs.push_back(mk(1'b1, 64'h1100, 1'b1, 64'h1100, 1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 64'h1104));
        vecs.push_back(mk(1'b1, 64'h1100, 1'b1, 64'h1100, 1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 64'h1104));
        vecs.push_back(mk(1'b1, 64'h1100, 1'b1, 64'h1100, 1'b1, 64'h900, 1'b0, 1'b1, 1'b0, 64'h1104));
        vecs.push_back(mk(1'b1, 64'h1100, 1'b1, 64'h1100, 1'b1, 64'h900, 1'b0, 1'b1, 1'b0, 64'h1104));
        vecs.push_back(mk(1'b1, 64'h1100, 1'b1, 64'h200,  1'b1, 64'hA00, 1'b1, 1'b1, 1'b1, 64'h900));
        vecs.push_back(mk(1'b1, 64'h200,  1'b0, 64'h0,    1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 64'h204));
        vecs.push_back(mk(1'b1, 64'h1100, 1'b1, 64'h1100, 1'b1, 64'hB00, 1'b0, 1'b0, 1'b0, 64'h1104));
        vecs.push_back(mk(1'b1, 64'h1100, 1'b1, 64'h104,  1'b1, 64'hC00, 1'b0, 1'b1, 1'b1, 64'hB00));
        vecs.push_back(mk(1'b0, 64'h104,  1'b0, 64'h0,    1'b0, 64'h0,   1'b0, 1'b1, 1'b1, 64'hC00));
        vecs.push_back(mk(1'b1, 64'h100,  1'b0, 64'h0,    1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 64'h104));
        vecs.push_back(mk(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0));
        vecs.push_back(mk(1'b0, 64'h1100, 1'b0, 64'h0,    1'b0, 64'h0,   1'b0, 1'b1, 1'b1, 64'hB00));
        vecs.push_back(mk(1'b1, 64'h104,  1'b1, 64'h104,  1'b0, 64'h0,   1'b0, 1'b1, 1'b1, 64'hC00));
        vecs.push_back(mk(1'b1, 64'h104,  1'b0, 64'h0,    1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 64'h108));

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        lookup_pc_in = 64'h100;
        #1;
        check("reset_hit", -1, {63'd0, hit_out}, 64'd0);
        check("reset_taken", -1, {63'd0, taken_out}, 64'd0);
        check("reset_ppc", -1, PPC_out, 64'h104);
        check("reset_lookups", -1, 64'(lookups_out), 64'd0);
        check("reset_hits", -1, 64'(hits_out), 64'd0);

        exp_lk = 0;
        exp_hits = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            lookup_valid_in = vecs[i].lkv;  lookup_pc_in  = vecs[i].lkpc;
            upd_valid_in    = vecs[i].uv;   upd_pc_in     = vecs[i].upc;
            upd_taken_in    = vecs[i].ut;   upd_target_in = vecs[i].utgt;
            flush_in        = vecs[i].fl;
            #1;
            check("hit", i, {63'd0, hit_out}, {63'd0, vecs[i].eh});
            check("taken", i, {63'd0, taken_out}, {63'd0, vecs[i].et});
            check("ppc", i, PPC_out, vecs[i].eppc);
            if (vecs[i].lkv) exp_lk++;
            if (vecs[i].lkv && vecs[i].eh) exp_hits++;
            @(posedge clock);
            #1;
            check("lookups", i, 64'(lookups_out), 64'(exp_lk));
            check("hits", i, 64'(hits_out), 64'(exp_hits));
        end

        // Reset coinciding with a pending allocate must discard it and clear all state.
        idle_inputs();
        upd_valid_in = 1'b1; upd_pc_in = 64'h300; upd_taken_in = 1'b1; upd_target_in = 64'hD00;
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        idle_inputs();
        lookup_valid_in = 1'b1;
        lookup_pc_in = 64'h300;
        #1;
        check("rst_pending_hit", -2, {63'd0, hit_out}, 64'd0);
        check("rst_pending_ppc", -2, PPC_out, 64'h304);
        check("rst_lookups", -2, 64'(lookups_out), 64'd0);
        check("rst_hits", -2, 64'(hits_out), 64'd0);
        lookup_pc_in = 64'h1100;
        #1;
        check("rst_clears_valid", -2, {63'd0, hit_out}, 64'd0);
        check("rst_clears_ppc", -2, PPC_out, 64'h1104);
        @(posedge clock);
        #1;
        check("post_rst_lookups", -2, 64'(lookups_out), 64'd1);

        // After reset an allocated entry starts at weakly-taken: one not-taken makes it predict fall-through.
        idle_inputs();
        upd_valid_in = 1'b1; upd_pc_in = 64'h108; upd_taken_in = 1'b1; upd_target_in = 64'hE00;
        @(posedge clock);
        #1;
        upd_taken_in = 1'b0; upd_target_in = 64'd0;
        lookup_pc_in = 64'h108;
        #1;
        check("alloc_taken", -3, {63'd0, taken_out}, 64'd1);
        check("alloc_ppc", -3, PPC_out, 64'hE00);
        @(posedge clock);
        #1;
        idle_inputs();
        lookup_pc_in = 64'h108;
        #1;
        check("nt_hit", -3, {63'd0, hit_out}, 64'd1);
        check("nt_ppc", -3, PPC_out, 64'h10C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
